// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared definitions for the programmable clock divider.
//   CNT_W        : default counter / period / high-time width
//   CFG_W        : width the clamp helper works in. Callers zero-extend
//                  into it and truncate back, so any CNT_W <= CFG_W works.
//   MIN_PERIOD   : shortest period the divider will run
//   cfg_t        : clamped {period, high} pair returned by clamp_cfg
//   clamp_cfg()  : maps a requested configuration onto a legal one
package clk_div_pkg;

  localparam int CNT_W = 20;
  localparam int CFG_W = 32;

  localparam logic [CFG_W-1:0] MIN_PERIOD = CFG_W'(2);

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
  } cfg_t;

  // Periods below MIN_PERIOD are raised to MIN_PERIOD. The high time is
  // limited to the clamped period, so a "too long" high time simply gives
  // a constant-high output instead of a meaningless comparison.
  function automatic cfg_t clamp_cfg(input logic [CFG_W-1:0] period,
                                     input logic [CFG_W-1:0] high);
    cfg_t r;
    r.period = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    r.high   = (high > r.period) ? r.period : high;
    return r;
  endfunction

endpackage

// File: rtl/prog_clk_div.sv
// prog_clk_div
//   Runtime-programmable clock divider with duty-cycle control. Produces a
//   divided square wave and a one-cycle strobe at the start of each period.
//   New settings are staged in a shadow register and copied into the active
//   register only when the counter wraps, so a period is never cut short
//   and no runt pulse appears on clock_out.
//
// Parameters
//   CNT_W      : counter, period and high-time width (<= clk_div_pkg::CFG_W)
//   DEF_PERIOD : period after reset; reset high time is DEF_PERIOD/2
//
// Ports
//   clk        : system clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   en         : run enable; low parks the counter and holds outputs low
//   cfg_valid  : configuration offered
//   cfg_ready  : shadow register free (no configuration pending)
//   cfg_period : requested period in clk cycles
//   cfg_high   : requested number of high cycles per period
//   clock_out  : registered divided clock
//   tick       : registered strobe, high on the first cycle of each period
//
// Configuration handshake
//   A transfer happens on a rising clk edge where cfg_valid && cfg_ready.
//   The source holds cfg_valid and the cfg_* fields stable until that edge;
//   cfg_ready does not depend on cfg_valid. After a transfer cfg_ready stays
//   low until the wrap that applies the staged values, so at most one
//   configuration is outstanding.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = clk_div_pkg::CNT_W,
  parameter int DEF_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clock_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H   = CNT_W'(DEF_PERIOD / 2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Active / shadow register bank
  logic [CNT_W-1:0] period_a;
  logic [CNT_W-1:0] high_a;
  logic [CNT_W-1:0] period_s;
  logic [CNT_W-1:0] high_s;
  logic             pend;

  logic [CNT_W-1:0] cnt;

  // Next-state helpers
  cfg_t             clamped;
  logic [CNT_W-1:0] clamped_period;
  logic [CNT_W-1:0] clamped_high;
  logic             cfg_fire;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] high_next;
  logic [CNT_W-1:0] period_last;

  assign cfg_ready = !pend;

  always_comb begin
    clamped        = clamp_cfg(CFG_W'(cfg_period), CFG_W'(cfg_high));
    clamped_period = CNT_W'(clamped.period);
    clamped_high   = CNT_W'(clamped.high);

    cfg_fire    = cfg_valid && !pend;

    // period_a is never below 2, so period_a-1 cannot underflow.
    period_last = period_a - ONE;
    wrap        = en && (cnt == period_last);
    apply       = wrap && pend;

    cnt_next    = wrap ? '0 : cnt + ONE;
    // The output for the first cycle of a period must already use the
    // high time that period will run with, hence the look-ahead.
    high_next   = apply ? high_s : high_a;
  end

  // The clamp helper works wider than the counter; its upper bits are
  // always zero because the inputs were zero-extended.
  if (CNT_W < CFG_W) begin : g_clamp_hi
    logic unused_clamp_hi;
    assign unused_clamp_hi = ^{clamped.period[CFG_W-1:CNT_W],
                               clamped.high[CFG_W-1:CNT_W]};
  end

  // Configuration staging: shadow registers and pend flag. A transfer can
  // only happen while pend is low, so it never coincides with an apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_s <= DEF_P;
      high_s   <= DEF_H;
      pend     <= 1'b0;
    end else if (cfg_fire) begin
      period_s <= clamped_period;
      high_s   <= clamped_high;
      pend     <= 1'b1;
    end else if (apply) begin
      pend     <= 1'b0;
    end
  end

  // Active settings change only on a wrap with a pending configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_a <= DEF_P;
      high_a   <= DEF_H;
    end else if (apply) begin
      period_a <= period_s;
      high_a   <= high_s;
    end
  end

  // Counter and registered outputs. While disabled the counter is parked
  // on the last count of the period so the first enabled edge wraps and
  // starts a clean period with a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= DEF_P - ONE;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (en) begin
      cnt       <= cnt_next;
      clock_out <= (cnt_next < high_next);
      tick      <= wrap;
    end else begin
      cnt       <= period_last;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div
//   Directed bench for prog_clk_div. Inputs change 1 ns after a rising
//   edge and outputs are sampled at the same point, away from the edge.
module tb_prog_clk_div;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_ready;
  logic         clock_out;
  logic         tick;

  int total = 0;
  int bad   = 0;

  prog_clk_div #(.CNT_W(W), .DEF_PERIOD(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .clock_out  (clock_out),
    .tick       (tick)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cfg_valid = 1'b0;
    cfg_period = '0;
    cfg_high = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Reset values and the first enabled edge after reset
  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    cfg_valid = 1'b0;
    step();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL reset_clk: got %b want 0", clock_out); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    rst_n = 1'b1;
    step();
    total++; if (clock_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL parked_outs: got clk=%b tick=%b want 0 0", clock_out, tick); end
    en = 1'b1;
    step();
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL first_tick: got %b want 1", tick); end
    total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL first_clk: got %b want 1", clock_out); end
    en = 1'b0;
  endtask

  // Default 1000/500 waveform over two periods
  task automatic test_default();
    int errs = 0;
    int first_bad = -1;
    int ticks = 0;
    int highs = 0;
    logic exp_clk, exp_tick;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      exp_tick = ((i % 1000) == 0);
      exp_clk  = ((i % 1000) < 500);
      if (tick === 1'b1) ticks++;
      if (clock_out === 1'b1) highs++;
      if (tick !== exp_tick || clock_out !== exp_clk) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL default_wave: got %0d bad cycles (first at %0d) want 0", errs, first_bad); end
    total++; if (ticks !== 2) begin bad++; $display("FAIL default_ticks: got %0d want 2", ticks); end
    total++; if (highs !== 1000) begin bad++; $display("FAIL default_highs: got %0d want 1000", highs); end
    en = 1'b0;
  endtask

  // Mid-period reconfiguration to period 4 / high 1
  task automatic test_cfg_small();
    int errs = 0;
    int first_bad = -1;
    logic exp_clk, exp_tick, exp_rdy;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 1012; i++) begin
      step();
      if (i < 1000) begin
        exp_clk  = (i < 500);
        exp_tick = (i == 0);
      end else begin
        exp_clk  = (((i - 1000) % 4) == 0);
        exp_tick = exp_clk;
      end
      exp_rdy = !(i >= 11 && i < 1000);
      if (clock_out !== exp_clk || tick !== exp_tick || cfg_ready !== exp_rdy) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      if (i == 1000) begin
        total++; if (tick !== 1'b1 || clock_out !== 1'b1) begin bad++; $display("FAIL small_apply: got clk=%b tick=%b want 1 1", clock_out, tick); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL small_ready_back: got %b want 1", cfg_ready); end
      end
      if (i == 1001) begin
        total++; if (clock_out !== 1'b0) begin bad++; $display("FAIL small_second: got %b want 0", clock_out); end
      end
      if (i == 10) begin
        cfg_period = W'(4);
        cfg_high = W'(1);
        cfg_valid = 1'b1;
      end
      if (i == 11) begin
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL small_ready_low: got %b want 0", cfg_ready); end
        cfg_valid = 1'b0;
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL small_wave: got %0d bad cycles (first at %0d) want 0", errs, first_bad); end
    en = 1'b0;
  endtask

  // Clamping and duty-cycle edge cases, loaded while disabled
  task automatic test_clamp();
    logic [W-1:0] vp [4] = '{W'(0), W'(5), W'(1), W'(3)};
    logic [W-1:0] vh [4] = '{W'(7), W'(0), W'(1), W'(2)};
    int           ep [4] = '{2, 5, 2, 3};
    int           eh [4] = '{2, 0, 1, 2};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      cfg_period = vp[v];
      cfg_high = vh[v];
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL clamp%0d_pend: got %b want 0", v, cfg_ready); end
      en = 1'b1;
      for (int j = 0; j < 3 * ep[v]; j++) begin
        step();
        total++; if (clock_out !== ((j % ep[v]) < eh[v])) begin bad++; $display("FAIL clamp%0d_clk@%0d: got %b want %b", v, j, clock_out, ((j % ep[v]) < eh[v])); end
        total++; if (tick !== ((j % ep[v]) == 0)) begin bad++; $display("FAIL clamp%0d_tick@%0d: got %b want %b", v, j, tick, ((j % ep[v]) == 0)); end
      end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL clamp%0d_ready: got %b want 1", v, cfg_ready); end
      en = 1'b0;
    end
  endtask

  // Transfer exactly on a wrap edge, and a refused second offer
  task automatic test_wrap_edge();
    int errs = 0;
    int first_bad = -1;
    logic exp_clk, exp_tick, exp_rdy;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 2006; i++) begin
      step();
      if (i < 2000) begin
        exp_clk  = ((i % 1000) < 500);
        exp_tick = ((i % 1000) == 0);
      end else begin
        exp_clk  = 1'b0;
        exp_tick = (((i - 2000) % 3) == 0);
      end
      exp_rdy = !(i >= 1000 && i < 2000);
      if (clock_out !== exp_clk || tick !== exp_tick || cfg_ready !== exp_rdy) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      if (i == 999) begin
        cfg_period = W'(3);
        cfg_high = W'(0);
        cfg_valid = 1'b1;
      end
      if (i == 1000) begin
        total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL wrapedge_old_kept: got %b want 1", clock_out); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL wrapedge_pend: got %b want 0", cfg_ready); end
        // Still offering, with different values, while pend is high.
        cfg_period = W'(7);
        cfg_high = W'(7);
      end
      if (i == 2000) begin
        total++; if (tick !== 1'b1 || clock_out !== 1'b0) begin bad++; $display("FAIL wrapedge_apply: got clk=%b tick=%b want 0 1", clock_out, tick); end
        cfg_valid = 1'b0;
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL wrapedge_wave: got %0d bad cycles (first at %0d) want 0", errs, first_bad); end
    en = 1'b0;
  endtask

  // Dropping en mid-period with a configuration taken while disabled
  task automatic test_en_drop();
    do_reset();
    cfg_period = W'(6);
    cfg_high = W'(3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    en = 1'b1;
    for (int j = 0; j < 3; j++) step();
    total++; if (clock_out !== 1'b1 || tick !== 1'b0) begin bad++; $display("FAIL endrop_before: got clk=%b tick=%b want 1 0", clock_out, tick); end
    en = 1'b0;
    cfg_period = W'(4);
    cfg_high = W'(4);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    total++; if (clock_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL endrop_outs: got clk=%b tick=%b want 0 0", clock_out, tick); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL endrop_cfg: got %b want 0", cfg_ready); end
    step();
    total++; if (clock_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL endrop_hold: got clk=%b tick=%b want 0 0", clock_out, tick); end
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      total++; if (clock_out !== 1'b1 || tick !== ((k % 4) == 0)) begin bad++; $display("FAIL reen@%0d: got clk=%b tick=%b want 1 %b", k, clock_out, tick, ((k % 4) == 0)); end
    end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reen_ready: got %b want 1", cfg_ready); end
    en = 1'b0;
  endtask

  // Asynchronous reset with a configuration pending
  task automatic test_async_reset();
    int errs = 0;
    int first_bad = -1;
    do_reset();
    en = 1'b1;
    step();
    cfg_period = W'(4);
    cfg_high = W'(1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    total++; if (clock_out !== 1'b1 || cfg_ready !== 1'b0) begin bad++; $display("FAIL arst_pre: got clk=%b rdy=%b want 1 0", clock_out, cfg_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (clock_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL arst_outs: got clk=%b tick=%b want 0 0", clock_out, tick); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL arst_ready: got %b want 1", cfg_ready); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 1001; i++) begin
      step();
      if (clock_out !== ((i % 1000) < 500) || tick !== ((i % 1000) == 0)) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      if (i == 1) begin
        total++; if (clock_out !== 1'b1) begin bad++; $display("FAIL arst_default_clk: got %b want 1", clock_out); end
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL arst_wave: got %0d bad cycles (first at %0d) want 0", errs, first_bad); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_cfg_small();
    test_clamp();
    test_wrap_edge();
    test_en_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Runtime-programmable clock divider with duty-cycle control and glitch-free reconfiguration, the successor to the fixed-period 50 % divider. It produces a square wave (`clock_out`) and a one-cycle period strobe (`tick`) from the system clock. The music player uses it as the tone and beat generator. The sequencer reloads period and high-time per note through a valid/ready port, and new settings take effect only on a period boundary, so no runt pulses are generated.

## Interface
- `CNT_W`, 20: counter, period and high-time width.
- `DEF_PERIOD`, 1000: period after reset, in clk cycles. Must satisfy 2 ≤ DEF_PERIOD < 2^CNT_W. Reset high-time is DEF_PERIOD/2 (floor).
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run enable; when low, the counter is parked and outputs are held low.
- `cfg_valid` input 1: new configuration offered.
- `cfg_ready` output 1: shadow register free; equals `!pend`.
- `cfg_period` input CNT_W: requested period in cycles.
- `cfg_high` input CNT_W: requested number of high cycles per period.
- `clock_out` output 1: registered divided clock.
- `tick` output 1: registered strobe, high for one cycle at the start of each period.

## Operation
- State:
  - active `period_a` and `high_a`
  - shadow `period_s` and `high_s`
  - `pend` flag
  - counter `cnt`
- Configuration handshake:
  - A transfer occurs when `cfg_valid && cfg_ready`.
  - On transfer, the clamped values go into the shadow registers and `pend <= 1`.
  - Clamping rules:
    - A period of 0 or 1 becomes 2.
    - A high-time greater than the clamped period becomes the clamped period.
- Wrap condition: `en && cnt == period_a-1`.
- On wrap:
  - `cnt <= 0`.
  - If `pend`, copy shadow to active and clear `pend`.
- When `en` is high and there is no wrap: `cnt <= cnt+1`.
- When `en` is low:
  - `cnt <= period_a-1`, so the first enabled edge wraps.
  - `clock_out <= 0`, `tick <= 0`.
  - Active and shadow registers are unchanged, and the handshake keeps working.
- Registered outputs on enabled cycles:
  - `clock_out <= (cnt_next < high_next)`, where `high_next` is the value of `high_a` after any shadow apply.
  - `tick <= wrap`.
  - `clock_out` therefore starts each period high for `high_a` cycles, then stays low for `period_a-high_a` cycles.
- Duty-cycle edge values:
  - `high_a == 0` gives a constant low.
  - `high_a == period_a` gives a constant high.
  - `tick` pulses every period in both cases.
- All arithmetic is unsigned CNT_W. Compare against `period_a-1`; the clamped period is never 0, so this cannot underflow.

## Timing
- Reset values:
  - `cnt = DEF_PERIOD-1`, `period_a = period_s = DEF_PERIOD`, `high_a = high_s = DEF_PERIOD/2`
  - `pend = 0`, `cfg_ready = 1`, `clock_out = 0`, `tick = 0`
- First enabled edge after reset or after `en` is low: wrap. That cycle shows `tick = 1` and `clock_out = (high_a > 0)`.
- Configuration latency: the new settings take effect at the first wrap strictly after the transfer edge.
  - A transfer on a wrap edge with `pend = 0` is applied at the following wrap, not the current one.
- `cfg_ready` deasserts the cycle after a transfer. It reasserts the cycle after the applying wrap. At most one configuration is outstanding.
- Dropping `en` mid-period: the next edge parks the counter and both outputs go low. A pending shadow is applied on the first wrap after re-enable.
- Reset asserted mid-operation clears all state immediately (asynchronous), including a pending configuration.

## Structure
- Shared package `clk_div_pkg`, containing:
  - `CNT_W` default
  - `MIN_PERIOD = 2`
  - a pure function `clamp_cfg(period, high)` that returns the clamped pair
- Single module with no sub-modules. The shadow/active pair is a small register bank inside the module.

## Test plan
- Reset then `en = 1` with defaults → `tick` every 1000 cycles. `clock_out` high for 500 cycles, low for 500; first high cycle coincides with `tick`.
- Transfer `cfg_period = 4`, `cfg_high = 1` at mid-period → old waveform finishes. Then `clock_out` pattern 1,0,0,0 repeats, with `tick` on each 1. `cfg_ready` is low from the transfer until the cycle after the applying wrap.
- Transfer `period = 0`, `high = 7` → behaves as period 2, high 2: `clock_out` constant 1, `tick` every 2 cycles. `period = 5`, `high = 0` → `clock_out` constant 0, `tick` every 5 cycles.
- Transfer on the exact wrap edge with `pend = 0` → settings applied one full old period later. A second `cfg_valid` while `pend = 1` is not accepted.
- Drop `en` at `cnt = 2` of a period-6 run → outputs go to 0 next edge. Reassert `en` → `tick` and a high `clock_out` on the first enabled cycle.
- Assert `rst_n = 0` asynchronously between edges while `pend = 1` → outputs drop without waiting for a clock edge. After release, the defaults apply (period 1000, high 500) and `cfg_ready = 1`.
